// File: rtl/corner_editor_multi.sv
// Manual corner editor: NUM_CORNERS (x,y) points, bulk-loaded and nudged per video field.
// Optional macro CORNER_WRAP_EN: wrap out-of-range coordinates instead of clamping.
module corner_editor_multi #(
  parameter int NUM_CORNERS = 4,
  parameter int COORD_W     = 10,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 1023,
  parameter int STEP_SLOW   = 1,
  parameter int STEP_FAST   = 8,
  parameter int HOLD_FIELDS = 16,
  localparam int SEL_W      = $clog2(NUM_CORNERS),
  localparam int BUS_W      = 2 * COORD_W * NUM_CORNERS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             field,
  input  logic             left_button,
  input  logic             right_button,
  input  logic             up_button,
  input  logic             down_button,
  input  logic             enter_button,
  input  logic [NUM_CORNERS-1:0] sel_buttons,
  input  logic [BUS_W-1:0] auto_corners,
  input  logic             set_corners,
  output logic [BUS_W-1:0] corners_out,
  output logic [SEL_W-1:0] active_corner,
  output logic             edit_mode,
  output logic             moved
);

  // Two guard bits keep x+step and x-step representable before limiting.
  localparam int SW = COORD_W + 2;
  localparam int HW = $clog2(HOLD_FIELDS + 1);
  localparam logic signed [SW-1:0] STEP_S  = SW'(STEP_SLOW);
  localparam logic signed [SW-1:0] STEP_F  = SW'(STEP_FAST);
  localparam logic signed [SW-1:0] XMAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0] YMAX_S  = SW'(Y_MAX);
  localparam logic signed [SW-1:0] XSPAN_S = SW'(X_MAX + 1);
  localparam logic signed [SW-1:0] YSPAN_S = SW'(Y_MAX + 1);
  localparam logic [HW-1:0]        HOLD_MAX = HW'(HOLD_FIELDS);

  typedef enum logic {LOCKED = 1'b0, EDIT = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic                   field_q, enter_q, field_tick, enter_tick;
  logic [COORD_W-1:0]     cx [NUM_CORNERS];
  logic [COORD_W-1:0]     cy [NUM_CORNERS];
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic [SEL_W-1:0]       sel_idx;
  logic                   sel_found;
  logic signed [SW-1:0]   step, x_sum, y_sum, x_lim, y_lim;
  logic [COORD_W-1:0]     x_new, y_new;
  logic                   any_dir, do_move, changed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOCKED;
    else          state <= state_nxt;
  end

  // A coincident enter edge toggles first so the same tick sees the new state.
  always_comb begin
    state_nxt = state;
    if (enter_tick) state_nxt = (state == LOCKED) ? EDIT : LOCKED;
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
      if (sel_buttons[i] && !sel_found) begin
        sel_idx   = SEL_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    any_dir = left_button | right_button | up_button | down_button;
    step    = (hold_cnt >= HOLD_MAX) ? STEP_F : STEP_S;
    x_sum   = $signed({2'b00, cx[active_corner]});
    y_sum   = $signed({2'b00, cy[active_corner]});
    if (right_button && !left_button)      x_sum = x_sum + step;
    else if (left_button && !right_button) x_sum = x_sum - step;
    if (down_button && !up_button)         y_sum = y_sum + step;
    else if (up_button && !down_button)    y_sum = y_sum - step;
`ifdef CORNER_WRAP_EN
    x_lim = x_sum;
    y_lim = y_sum;
    if (x_sum < 0)           x_lim = x_sum + XSPAN_S;
    else if (x_sum > XMAX_S) x_lim = x_sum - XSPAN_S;
    if (y_sum < 0)           y_lim = y_sum + YSPAN_S;
    else if (y_sum > YMAX_S) y_lim = y_sum - YSPAN_S;
`else
    x_lim = x_sum;
    y_lim = y_sum;
    if (x_sum < 0)           x_lim = '0;
    else if (x_sum > XMAX_S) x_lim = XMAX_S;
    if (y_sum < 0)           y_lim = '0;
    else if (y_sum > YMAX_S) y_lim = YMAX_S;
`endif
    x_new   = x_lim[COORD_W-1:0];
    y_new   = y_lim[COORD_W-1:0];
    changed = (x_new != cx[active_corner]) || (y_new != cy[active_corner]);
    do_move = field_tick && !set_corners && (state_nxt == EDIT);
  end

  always_comb begin
    hold_nxt = hold_cnt;
    if (state_nxt == LOCKED) begin
      hold_nxt = '0;
    end else if (field_tick) begin
      if (set_corners || !any_dir) hold_nxt = '0;
      else if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      field_q       <= 1'b0;
      enter_q       <= 1'b0;
      field_tick    <= 1'b0;
      enter_tick    <= 1'b0;
      hold_cnt      <= '0;
      active_corner <= '0;
      moved         <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
      end
    end else begin
      field_q    <= field;
      enter_q    <= enter_button;
      field_tick <= field & ~field_q;
      enter_tick <= enter_button & ~enter_q;
      hold_cnt   <= hold_nxt;
      moved      <= 1'b0;
      if (sel_found) active_corner <= sel_idx;
      if (set_corners) begin
        for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
          cx[i] <= auto_corners[(NUM_CORNERS-1-i)*2*COORD_W + COORD_W +: COORD_W];
          cy[i] <= auto_corners[(NUM_CORNERS-1-i)*2*COORD_W +: COORD_W];
        end
      end else if (do_move) begin
        cx[active_corner] <= x_new;
        cy[active_corner] <= y_new;
        moved             <= changed;
      end
    end
  end

  always_comb begin
    corners_out = '0;
    for (int unsigned i = 0; i < NUM_CORNERS; i++) begin
      corners_out[(NUM_CORNERS-1-i)*2*COORD_W + COORD_W +: COORD_W] = cx[i];
      corners_out[(NUM_CORNERS-1-i)*2*COORD_W +: COORD_W]           = cy[i];
    end
  end

  assign edit_mode = (state == EDIT);

endmodule

// File: tb/tb_corner_editor_multi.sv
// Directed bench for corner_editor_multi (N=4, W=10, HOLD_FIELDS=4), default clamp build.
module tb_corner_editor_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        field, left_button, right_button, up_button, down_button, enter_button;
  logic [3:0]  sel_buttons;
  logic [79:0] auto_corners;
  logic        set_corners;
  logic [79:0] corners_out;
  logic [1:0]  active_corner;
  logic        edit_mode, moved;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  corner_editor_multi #(
    .NUM_CORNERS(4), .COORD_W(10), .X_MAX(1023), .Y_MAX(1023),
    .STEP_SLOW(1), .STEP_FAST(8), .HOLD_FIELDS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .field(field),
    .left_button(left_button), .right_button(right_button),
    .up_button(up_button), .down_button(down_button),
    .enter_button(enter_button), .sel_buttons(sel_buttons),
    .auto_corners(auto_corners), .set_corners(set_corners),
    .corners_out(corners_out), .active_corner(active_corner),
    .edit_mode(edit_mode), .moved(moved)
  );

  localparam logic [79:0] L1 = {10'd192, 10'd144, 10'd832, 10'd144,
                                10'd192, 10'd880, 10'd832, 10'd880};
  localparam logic [79:0] L2 = {10'd192, 10'd144, 10'd832, 10'd144,
                                10'd3,   10'd880, 10'd832, 10'd880};

  typedef struct {
    int   c;
    logic l, r, u, d;
    int   ex, ey;
    logic em;
  } vec_t;

  vec_t tbl [0:23];

  function automatic int get_x(input int i);
    return int'(corners_out[(3-i)*20 + 10 +: 10]);
  endfunction

  function automatic int get_y(input int i);
    return int'(corners_out[(3-i)*20 +: 10]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [79:0] act, input logic [79:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_dirs(input logic l, input logic r, input logic u, input logic d);
    left_button = l; right_button = r; up_button = u; down_button = d;
  endtask

  task automatic do_load(input logic [79:0] v);
    @(negedge clk);
    auto_corners = v;
    set_corners  = 1'b1;
    @(negedge clk);
    set_corners = 1'b0;
    check_bus("load", corners_out, v);
  endtask

  task automatic pulse_enter(input int exp_edit);
    @(negedge clk); enter_button = 1'b1;
    @(negedge clk); enter_button = 1'b0;
    @(negedge clk);
    check("edit_mode_after_enter", int'(edit_mode), exp_edit);
  endtask

  task automatic do_sel(input logic [3:0] bits, input int exp_idx);
    @(negedge clk); sel_buttons = bits;
    @(negedge clk); sel_buttons = '0;
    check("active_corner", int'(active_corner), exp_idx);
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    set_dirs(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d);
    field = 1'b1;
    @(negedge clk); field = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_x", i), get_x(tbl[i].c), tbl[i].ex);
    check($sformatf("vec%0d_y", i), get_y(tbl[i].c), tbl[i].ey);
    check($sformatf("vec%0d_moved", i), int'(moved), int'(tbl[i].em));
  endtask

  task automatic idle_tick();
    @(negedge clk);
    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
    field = 1'b1;
    @(negedge clk); field = 1'b0;
    @(negedge clk);
    check("idle_moved", int'(moved), 0);
  endtask

  initial begin
    // locked: left on corner 0 does nothing
    for (int i = 0; i < 5; i++) tbl[i] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 192, 144, 1'b0};
    // edit: right on corner 1, accelerates after 4 held ticks
    tbl[5]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 833, 144, 1'b1};
    tbl[6]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 834, 144, 1'b1};
    tbl[7]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 835, 144, 1'b1};
    tbl[8]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 836, 144, 1'b1};
    tbl[9]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 844, 144, 1'b1};
    tbl[10] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 852, 144, 1'b1};
    // left on corner 2 from x=3 clamps at 0
    tbl[11] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 2, 880, 1'b1};
    tbl[12] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 880, 1'b1};
    tbl[13] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 880, 1'b1};
    tbl[14] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 880, 1'b0};
    tbl[15] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 880, 1'b0};
    tbl[16] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 880, 1'b0};
    // left+right cancel, down moves corner 3
    tbl[17] = '{3, 1'b1, 1'b1, 1'b0, 1'b1, 832, 881, 1'b1};
    tbl[18] = '{3, 1'b1, 1'b1, 1'b0, 1'b1, 832, 882, 1'b1};
    // right on corner 3, hold count carries over (2) from the previous pair
    tbl[19] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 833, 882, 1'b1};
    tbl[20] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 834, 882, 1'b1};
    tbl[21] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 842, 882, 1'b1};
    tbl[22] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 850, 882, 1'b1};
    tbl[23] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 858, 882, 1'b1};

    reset_n = 1'b0; field = 1'b0; enter_button = 1'b0;
    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
    sel_buttons = '0; auto_corners = '0; set_corners = 1'b0;
    repeat (3) @(negedge clk);
    check_bus("reset_corners", corners_out, '0);
    check("reset_active", int'(active_corner), 0);
    check("reset_edit", int'(edit_mode), 0);
    check("reset_moved", int'(moved), 0);
    reset_n = 1'b1;

    do_load(L1);
    check("edit_after_load", int'(edit_mode), 0);
    for (int i = 0; i <= 4; i++) run_vec(i);

    pulse_enter(1);
    do_sel(4'b0010, 1);
    for (int i = 5; i <= 10; i++) run_vec(i);
    idle_tick();

    do_load(L2);
    check("edit_kept_by_load", int'(edit_mode), 1);
    do_sel(4'b0100, 2);
    for (int i = 11; i <= 16; i++) run_vec(i);
    idle_tick();

    do_sel(4'b1000, 3);
    for (int i = 17; i <= 23; i++) run_vec(i);

    // load coincident with the tick: load wins and the hold count restarts
    @(negedge clk); field = 1'b1;
    @(negedge clk); field = 1'b0; auto_corners = L1; set_corners = 1'b1;
    @(negedge clk); set_corners = 1'b0;
    check_bus("coincident_load", corners_out, L1);
    check("coincident_moved", int'(moved), 0);
    @(negedge clk); field = 1'b1;
    @(negedge clk); field = 1'b0;
    @(negedge clk);
    check("post_load_slow_x", get_x(3), 833);
    check("post_load_moved", int'(moved), 1);

    pulse_enter(0);
    @(negedge clk); field = 1'b1;
    @(negedge clk); field = 1'b0;
    @(negedge clk);
    check("locked_x", get_x(3), 833);
    check("locked_moved", int'(moved), 0);

    // asynchronous reset in the middle of a pending tick
    @(negedge clk); field = 1'b1;
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    check_bus("async_reset_corners", corners_out, '0);
    check("async_reset_active", int'(active_corner), 0);
    check("async_reset_moved", int'(moved), 0);
    @(negedge clk); field = 1'b0; set_dirs(1'b0, 1'b0, 1'b0, 1'b0); reset_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
